// File: rtl/pipo_arbiter.sv
// Two-requester arbiter in front of a shared parallel-in parallel-out register.
// The owner reloads the register every cycle for up to HOLD cycles per grant.
// On release, ownership moves straight to the other requester when it is
// waiting; a tie out of IDLE is settled by a round-robin pointer.
module pipo_arbiter #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] q,
    output logic             load,
    output logic             owner
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    // Loads left in the current grant after the one just made.
    localparam logic [3:0] CNT_INIT = 4'(HOLD - 1);

    state_t     state;
    logic       prio;
    logic [3:0] cnt;

    logic       cur;        // index of the current owner
    logic       own_req;    // current owner still requesting
    logic       oth_req;    // the other requester is asserted
    logic       stay;       // owner keeps the register this edge
    logic       any_req;
    logic       win;        // index granted when a new grant is made

    // Decide between continuing the current grant and handing out a new one.
    always_comb begin
        cur     = (state == OWN1);
        own_req = cur ? req1 : req0;
        oth_req = cur ? req0 : req1;
        any_req = req0 | req1;
        stay    = (state != IDLE) && own_req && (cnt != 4'd0);
        win     = 1'b0;
        if (state == IDLE)
            win = (req0 && req1) ? prio : req1;
        else
            win = oth_req ? ~cur : cur;
    end

    // Arbitration state, shared register and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= 4'd0;
            q     <= '0;
            load  <= 1'b0;
            owner <= 1'b0;
        end else if (stay) begin
            q     <= cur ? a1 : a0;
            cnt   <= cnt - 4'd1;
            load  <= 1'b1;
        end else if (any_req) begin
            state <= win ? OWN1 : OWN0;
            q     <= win ? a1 : a0;
            owner <= win;
            cnt   <= CNT_INIT;
            prio  <= ~win;
            load  <= 1'b1;
        end else begin
            state <= IDLE;
            load  <= 1'b0;
        end
    end

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

endmodule

// File: tb/tb_pipo_arbiter.sv
// Directed bench for pipo_arbiter: a vector table for the HOLD=3 instance
// plus hand sequences for asynchronous reset and HOLD=1 alternation.
module tb_pipo_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, a1 = '0;

    logic       gnt0, gnt1, load, owner;
    logic [3:0] q;
    logic       gnt0b, gnt1b, loadb, ownerb;
    logic [3:0] qb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipo_arbiter #(.WIDTH(4), .HOLD(3)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .a1(a1),
        .gnt0(gnt0), .gnt1(gnt1), .q(q), .load(load), .owner(owner)
    );

    pipo_arbiter #(.WIDTH(4), .HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .a1(a1),
        .gnt0(gnt0b), .gnt1(gnt1b), .q(qb), .load(loadb), .owner(ownerb)
    );

    typedef struct {
        logic       rst, r0, r1;
        logic [3:0] a0, a1;
        logic       g0, g1;
        logic [3:0] q;
        logic       ld, own;
    } vec_t;

    localparam int NV = 23;
    vec_t tv [NV];

    // Outputs packed as {gnt0, gnt1, q, load, owner}.
    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got g0g1=%b q=%b ld=%b own=%b, expected g0g1=%b q=%b ld=%b own=%b",
                     name, got[7:6], got[5:2], got[1], got[0], exp[7:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [7:0] pk(logic g0, logic g1, logic [3:0] qq, logic ld, logic ow);
        return {g0, g1, qq, ld, ow};
    endfunction

    initial begin
        //          rst  r0 r1  a0     a1      g0 g1 q      ld own
        tv[0]  = '{1'b0,1'b1,1'b0,4'hD,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0}; // reset holds
        tv[1]  = '{1'b0,1'b1,1'b0,4'hD,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0};
        tv[2]  = '{1'b1,1'b1,1'b0,4'hD,4'h0, 1'b1,1'b0,4'hD,1'b1,1'b0}; // grant 0
        tv[3]  = '{1'b1,1'b1,1'b0,4'hD,4'h0, 1'b1,1'b0,4'hD,1'b1,1'b0};
        tv[4]  = '{1'b1,1'b1,1'b0,4'h8,4'h0, 1'b1,1'b0,4'h8,1'b1,1'b0}; // new data tracks
        tv[5]  = '{1'b1,1'b1,1'b0,4'h8,4'h0, 1'b1,1'b0,4'h8,1'b1,1'b0}; // re-grant, no gap
        tv[6]  = '{1'b1,1'b0,1'b0,4'h8,4'h0, 1'b0,1'b0,4'h8,1'b0,1'b0}; // idle, q holds
        tv[7]  = '{1'b0,1'b0,1'b0,4'h8,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0}; // reset
        tv[8]  = '{1'b1,1'b1,1'b1,4'hD,4'h8, 1'b1,1'b0,4'hD,1'b1,1'b0}; // tie -> 0
        tv[9]  = '{1'b1,1'b1,1'b1,4'hD,4'h8, 1'b1,1'b0,4'hD,1'b1,1'b0};
        tv[10] = '{1'b1,1'b1,1'b1,4'hD,4'h8, 1'b1,1'b0,4'hD,1'b1,1'b0};
        tv[11] = '{1'b1,1'b1,1'b1,4'hD,4'h8, 1'b0,1'b1,4'h8,1'b1,1'b1}; // hold expired -> 1
        tv[12] = '{1'b1,1'b1,1'b1,4'hD,4'h8, 1'b0,1'b1,4'h8,1'b1,1'b1};
        tv[13] = '{1'b1,1'b1,1'b1,4'hD,4'h8, 1'b0,1'b1,4'h8,1'b1,1'b1};
        tv[14] = '{1'b1,1'b1,1'b1,4'hD,4'h8, 1'b1,1'b0,4'hD,1'b1,1'b0}; // back to 0
        tv[15] = '{1'b1,1'b0,1'b1,4'hD,4'h8, 1'b0,1'b1,4'h8,1'b1,1'b1}; // early drop -> 1
        tv[16] = '{1'b1,1'b0,1'b1,4'hD,4'h8, 1'b0,1'b1,4'h8,1'b1,1'b1};
        tv[17] = '{1'b1,1'b0,1'b0,4'hF,4'hF, 1'b0,1'b0,4'h8,1'b0,1'b1}; // idle, owner 1
        tv[18] = '{1'b1,1'b0,1'b0,4'hF,4'hF, 1'b0,1'b0,4'h8,1'b0,1'b1};
        tv[19] = '{1'b1,1'b0,1'b1,4'hF,4'h3, 1'b0,1'b1,4'h3,1'b1,1'b1}; // sole req1
        tv[20] = '{1'b1,1'b1,1'b1,4'h6,4'h5, 1'b0,1'b1,4'h5,1'b1,1'b1}; // owner keeps it
        tv[21] = '{1'b1,1'b1,1'b1,4'h6,4'h5, 1'b0,1'b1,4'h5,1'b1,1'b1};
        tv[22] = '{1'b1,1'b1,1'b1,4'h6,4'h5, 1'b1,1'b0,4'h6,1'b1,1'b0}; // waiting 0 served

        // Reset is asserted from time zero: outputs cleared before any edge.
        #1;
        check("reset_t0", pk(gnt0, gnt1, q, load, owner), pk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0));

        for (int i = 0; i < NV; i++) begin
            rst = tv[i].rst; req0 = tv[i].r0; req1 = tv[i].r1;
            a0 = tv[i].a0;   a1 = tv[i].a1;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), pk(gnt0, gnt1, q, load, owner),
                  pk(tv[i].g0, tv[i].g1, tv[i].q, tv[i].ld, tv[i].own));
        end

        // Asynchronous reset in the middle of an OWN1 grant.
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; req1 = 1'b1; a0 = 4'hD; a1 = 4'h8;
        @(posedge clk); #1;
        check("own1_setup", pk(gnt0, gnt1, q, load, owner), pk(1'b0, 1'b1, 4'h8, 1'b1, 1'b1));
        #2;
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        #1;
        check("async_rst", pk(gnt0, gnt1, q, load, owner), pk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0));
        @(posedge clk); #1;
        check("rst_edge", pk(gnt0, gnt1, q, load, owner), pk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tie", pk(gnt0, gnt1, q, load, owner), pk(1'b1, 1'b0, 4'hD, 1'b1, 1'b0));

        // HOLD=1 instance: both requesting alternates every edge.
        rst = 1'b0;
        @(posedge clk); #1;
        check("h1_reset", pk(gnt0b, gnt1b, qb, loadb, ownerb), pk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0));
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; a0 = 4'hD; a1 = 4'h8;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k % 2 == 0)
                check($sformatf("h1_alt%0d", k), pk(gnt0b, gnt1b, qb, loadb, ownerb),
                      pk(1'b1, 1'b0, 4'hD, 1'b1, 1'b0));
            else
                check($sformatf("h1_alt%0d", k), pk(gnt0b, gnt1b, qb, loadb, ownerb),
                      pk(1'b0, 1'b1, 4'h8, 1'b1, 1'b1));
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        check("h1_idle", pk(gnt0b, gnt1b, qb, loadb, ownerb), pk(1'b0, 1'b0, 4'h8, 1'b0, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipo_arbiter.md
PIPO_ARBITER -- requirements
Module: pipo_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of the shared parallel-in parallel-out register.
REQ-002 SHALL have parameter HOLD, default 3, the maximum number of consecutive load cycles per grant (legal range 1..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port req0  input  1  requester 0 wants the shared register.
REQ-006 SHALL have port req1  input  1  requester 1 wants the shared register.
REQ-007 SHALL have port a0  input  WIDTH  requester 0 parallel data.
REQ-008 SHALL have port a1  input  WIDTH  requester 1 parallel data.
REQ-009 SHALL have port gnt0  output  1  registered, requester 0 owns the register.
REQ-010 SHALL have port gnt1  output  1  registered, requester 1 owns the register.
REQ-011 SHALL have port q  output  WIDTH  shared register contents.
REQ-012 SHALL have port load  output  1  registered, high in every cycle whose preceding edge wrote q.
REQ-013 SHALL have port owner  output  1  index of the requester that last wrote q.

Function
REQ-014 SHALL implement FSM states IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1); gnt0 and gnt1 never both 1.
REQ-015 SHALL keep a round-robin pointer prio: 0 favours req0 on a tie, 1 favours req1; on each grant, prio is set to the non-granted index.
REQ-016 SHALL, in IDLE with no req: hold q, load=0, remain IDLE.
REQ-017 SHALL, in IDLE with req asserted: pick the winner (sole requester, or prio on a tie); on that edge enter OWNx, q<=ax, owner<=x, cnt<=HOLD-1, load=1 in the following cycle.
REQ-018 SHALL, in OWNx with reqx=1 and cnt>0: on each edge q<=ax (transparent parallel load), cnt<=cnt-1, load=1.
REQ-019 SHALL release OWNx at the edge where reqx=0 or cnt==0; no write of ax on a reqx=0 release edge.
REQ-020 SHALL, on release, when the other requester is asserted: enter OWNother on the same edge (no IDLE bubble), load its data and apply REQ-017 to it.
REQ-021 SHALL, on release by cnt==0 with only reqx asserted: re-grant x (stay in OWNx, q<=ax, cnt<=HOLD-1).
REQ-022 SHALL, on release with no requester asserted: enter IDLE, q holds its last value, load=0.
REQ-023 SHALL with HOLD=1 and both requesting: alternate ownership every cycle.
REQ-024 SHALL never change q except on a load edge; q is full WIDTH, no truncation or extension.
REQ-025 SHALL give a requester its grant within at most HOLD+1 edges of asserting req while the other holds.

Reset
REQ-026 SHALL on rst=0 immediately (asynchronously) set state=IDLE, q=0, gnt0=gnt1=0, load=0, owner=0, prio=0, cnt=0.
REQ-027 SHALL resume arbitration from the first rising edge after rst returns to 1; a mid-ownership reset discards the grant.

Verification
REQ-028 SHALL cover: rst=0 with req0=1, a0=1101 -> q=0000, gnt0=gnt1=0, load=0 immediately, no change on clock edges.
REQ-029 SHALL cover: req0 only, a0=1101, then a0=1000 after 2 cycles -> gnt0=1, q=1101, load=1 after edge 1; q=1000 after the next edge; gnt0 stays 1 across the HOLD re-grant.
REQ-030 SHALL cover: req0=req1=1 from reset, a0=1101, a1=1000, HOLD=3 -> gnt0 for 3 edges (q=1101), then gnt1 for 3 edges (q=1000), alternating, owner following.
REQ-031 SHALL cover: OWN0 with req0 dropped after 1 load while req1=1 -> the next edge gives gnt1=1, q=a1, load=1, no IDLE cycle.
REQ-032 SHALL cover: both req dropped in OWN1 with q=1000 -> IDLE, gnt=00, load=0, q stays 1000, owner=1.
REQ-033 SHALL cover: rst=0 mid-OWN1 (q=1000), release with both req=1 -> q=0000 at once; after release, gnt0 wins first.
